pc_control: RTL and testbench
=============================

# pc_control

Program-counter and branch-resolution stage for the single-cycle 16-bit CPU. Holds the PC and the architectural N/Z/V flag register, resolves B/BR/PCS/HLT, and presents the next fetch address to instruction memory. The fetched instruction feeds the opcode decoder, so this block sits directly upstream of it. The block also owns the halt state and a retired-instruction counter.

## Interface
- No parameters. Data width is fixed at 16, PC step is 2, opcode is `instr[15:12]`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  16  instruction fetched from `pc` this cycle.
- `rs_data`  in  16  register-file read of rs (`instr[7:4]`), used as the BR target.
- `alu_z`, `alu_v`, `alu_n`  in  1 each  ALU flag results for the current instruction.
- `stall`  in  1  hold all state this cycle (memory wait).
- `pc`  out  16  current fetch address (registered).
- `pc_plus2`  out  16  `pc + 2`, wraps modulo 2^16; this is the PCS write-back value.
- `flags`  out  3  registered `{N,Z,V}`.
- `taken`  out  1  combinational: the current B/BR redirects the PC.
- `hlt`  out  1  registered: the CPU is halted.
- `inst_count`  out  16  registered count of retired instructions.

## Operation
- Opcode map:
  - ADD=0000, SUB=0001, XOR=0010, RED=0011, SLL=0100, SRA=0101, ROR=0110, PADDSB=0111
  - LW=1000, SW=1001, LHB=1010, LLB=1011
  - B=1100, BR=1101, PCS=1110, HLT=1111
- Flag writes on a retiring instruction:
  - ADD and SUB write N, Z and V.
  - XOR, SLL, SRA and ROR write Z only.
  - All other opcodes leave the flags unchanged.
- Branch condition `ccc = instr[11:9]`, always evaluated on the registered flags, never on the current ALU flags:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 or (Z=0 and N=0)
  - 101 LTE: N=1 or Z=1
  - 110 OVF: V=1
  - 111 always
- B target: `pc_plus2 + (sext(instr[8:0]) << 1)`, computed in 16 bits with wrap.
- BR target: `rs_data`, with bit 0 passed through unmodified.
- Not-taken branches and all non-branch opcodes advance to `pc_plus2`.
- FSM has two states, RUN and HALTED.
  - RUN, stall=0, opcode≠HLT: the instruction retires. PC goes to its next value, flags update per the rules above, `inst_count` increments.
  - RUN, stall=0, opcode=HLT: the HLT retires and the FSM moves to HALTED. `inst_count` increments, PC holds at the HLT address, `hlt` is 1 from the next cycle.
  - RUN, stall=1: no state changes. `taken` is still driven combinationally.
  - HALTED: `instr`, `stall` and all flag inputs are ignored and `taken`=0. Only `rst` leaves this state.

## Timing
- Reset values: `pc`=0x0000, `flags`=000, `hlt`=0, `inst_count`=0x0000, FSM=RUN.
- `pc_plus2` reads 0x0002 during reset.
- `rst` overrides `stall`, HLT and any branch in the same cycle. Reset mid-execution or while HALTED restarts at 0x0000 on the next edge.
- Latency is zero from `instr` to the PC decision: `taken` and the next PC are combinational, the PC register loads on the next edge.
- A flag-setting instruction immediately followed by a branch: the branch sees the new flags, because they registered at the edge between the two.
- Wrap-around:
  - `pc`=0xFFFE advances to 0x0000.
  - A B target wraps modulo 2^16.
  - `inst_count` wraps 0xFFFF → 0x0000.
- `stall` together with HLT or a taken branch: stall wins and nothing retires.

## Structure
- Package `cpu_pkg` holds:
  - opcode constants
  - condition-code constants
  - FSM state enum `{RUN, HALTED}`
  - the flag-index constants N=2, Z=1, V=0
- Sub-module `branch_cond`: combinational, inputs `ccc` and `flags`, output `cond_true`.
- Everything else lives in `pc_control`.

## Test plan
- Reset then three ADDs (0x0xxx), stall=0: pc goes 0x0000 → 0x0002 → 0x0004 → 0x0006, `inst_count`=3.
- SUB with alu_z=1 at pc=0x0010, then B EQ with imm9=0x1FE (-2) at pc=0x0012: `taken`=1, pc becomes 0x0010.
- XOR with alu_z=0, alu_n=1, alu_v=1 applied after flags=000: flags become 000, because XOR writes Z only. A following B OVF is not taken, pc advances by 2.
- BR always (ccc=111) with `rs_data`=0xBEEF at pc=0x0040: pc becomes 0xBEEF, and 0xBEF1 on the next non-branch instruction.
- Two edges with stall=1 during a taken B: pc, flags and count are unchanged. After stall drops, the branch retires once.
- HLT at pc=0x0020:
  - Next cycle `hlt`=1, pc holds at 0x0020, the count increments once, then freezes for 10 cycles of random `instr`.
  - Asserting `rst` returns pc to 0x0000 and `hlt` to 0.
- PC at 0xFFFE with a non-branch instruction: pc becomes 0x0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, branch condition codes, FSM states and flag indices for the 16-bit CPU
package cpu_pkg;
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LHB    = 4'hA;
    localparam logic [3:0] OP_LLB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GTE = 3'b100;
    localparam logic [2:0] CC_LTE = 3'b101;
    localparam logic [2:0] CC_OVF = 3'b110;
    localparam logic [2:0] CC_AL  = 3'b111;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {RUN, HALTED} state_t;
endpackage

// File: rtl/branch_cond.sv
// branch_cond: evaluates a 3-bit branch condition against the registered {N,Z,V} flags
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       cond_true
);
    logic n, z, v;
    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_true = 1'b1;
        case (ccc)
            CC_NE:   cond_true = !z;
            CC_EQ:   cond_true = z;
            CC_GT:   cond_true = !z && !n;
            CC_LT:   cond_true = n;
            CC_GTE:  cond_true = z || !n;
            CC_LTE:  cond_true = n || z;
            CC_OVF:  cond_true = v;
            default: cond_true = 1'b1;
        endcase
    end
endmodule

// File: rtl/pc_control.sv
// pc_control: PC register, flag register, branch resolution, halt FSM and retired-instruction count
module pc_control
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic [15:0] rs_data,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_n,
    input  logic        stall,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic [2:0]  flags,
    output logic        taken,
    output logic        hlt,
    output logic [15:0] inst_count
);
    state_t      state, state_next;
    logic [3:0]  opcode;
    logic        is_b, is_br, cond_true, retire, wr_nzv, wr_z;
    logic [15:0] b_target, next_pc;
    logic [2:0]  flags_next;

    assign opcode = instr[15:12];
    assign is_b   = opcode == OP_B;
    assign is_br  = opcode == OP_BR;
    assign wr_nzv = opcode == OP_ADD || opcode == OP_SUB;
    assign wr_z   = opcode == OP_XOR || opcode == OP_SLL || opcode == OP_SRA || opcode == OP_ROR;
    assign retire = state == RUN && !stall;
    assign hlt    = state == HALTED;

    // pc is not yet defined before the first reset edge, so force the reset view
    assign pc_plus2 = rst ? 16'h0002 : pc + 16'h0002;
    assign b_target = pc_plus2 + {{6{instr[8]}}, instr[8:0], 1'b0};

    branch_cond u_branch_cond (
        .ccc       (instr[11:9]),
        .flags     (flags),
        .cond_true (cond_true)
    );

    assign taken   = state == RUN && (is_b || is_br) && cond_true;
    assign next_pc = !taken ? pc_plus2 : is_br ? rs_data : b_target;

    always_comb begin
        flags_next = flags;
        if (wr_nzv) flags_next = {alu_n, alu_z, alu_v};
        else if (wr_z) flags_next[FLAG_Z] = alu_z;
    end

    always_comb begin
        state_next = state;
        if (retire && opcode == OP_HLT) state_next = HALTED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc         <= 16'h0000;
            flags      <= 3'b000;
            inst_count <= 16'h0000;
        end else begin
            state <= state_next;
            if (retire) begin
                inst_count <= inst_count + 16'h0001;
                flags      <= flags_next;
                if (opcode != OP_HLT) pc <= next_pc;
            end
        end
    end
endmodule

// File: tb/tb_pc_control.sv
// tb_pc_control: directed vector table plus halt, reset and wrap sequences for pc_control
module tb_pc_control;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr, rs_data;
    logic        alu_z, alu_v, alu_n, stall;
    logic [15:0] pc, pc_plus2, inst_count;
    logic [2:0]  flags;
    logic        taken, hlt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pc_control dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .rs_data    (rs_data),
        .alu_z      (alu_z),
        .alu_v      (alu_v),
        .alu_n      (alu_n),
        .stall      (stall),
        .pc         (pc),
        .pc_plus2   (pc_plus2),
        .flags      (flags),
        .taken      (taken),
        .hlt        (hlt),
        .inst_count (inst_count)
    );

    typedef struct {
        logic [15:0] instr;
        logic [15:0] rs;
        logic [2:0]  alu;
        logic        stall;
        logic        taken;
        logic [15:0] pc;
        logic [2:0]  flags;
        logic [15:0] cnt;
        logic        hlt;
    } vec_t;

    vec_t vecs[26];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t v);
        instr   = v.instr;
        rs_data = v.rs;
        {alu_n, alu_z, alu_v} = v.alu;
        stall   = v.stall;
        #4;
        chk("taken", {15'b0, taken}, {15'b0, v.taken});
        @(posedge clk);
        #1;
        chk("pc", pc, v.pc);
        chk("pc_plus2", pc_plus2, v.pc + 16'h0002);
        chk("flags", {13'b0, flags}, {13'b0, v.flags});
        chk("inst_count", inst_count, v.cnt);
        chk("hlt", {15'b0, hlt}, {15'b0, v.hlt});
    endtask

    initial begin
        //         instr     rs        nzv     stall taken pc        flags   cnt    hlt
        vecs[0]  = '{16'h0123, 16'h0000, 3'b000, 1'b0, 1'b0, 16'h0002, 3'b000, 16'd1,  1'b0};
        vecs[1]  = '{16'h0456, 16'h0000, 3'b000, 1'b0, 1'b0, 16'h0004, 3'b000, 16'd2,  1'b0};
        vecs[2]  = '{16'h0789, 16'h0000, 3'b000, 1'b0, 1'b0, 16'h0006, 3'b000, 16'd3,  1'b0};
        vecs[3]  = '{16'hCE04, 16'h0000, 3'b000, 1'b0, 1'b1, 16'h0010, 3'b000, 16'd4,  1'b0};
        vecs[4]  = '{16'h1000, 16'h0000, 3'b010, 1'b0, 1'b0, 16'h0012, 3'b010, 16'd5,  1'b0};
        vecs[5]  = '{16'hC3FE, 16'h0000, 3'b000, 1'b0, 1'b1, 16'h0010, 3'b010, 16'd6,  1'b0};
        vecs[6]  = '{16'h1000, 16'h0000, 3'b000, 1'b0, 1'b0, 16'h0012, 3'b000, 16'd7,  1'b0};
        vecs[7]  = '{16'h2000, 16'h0000, 3'b101, 1'b0, 1'b0, 16'h0014, 3'b000, 16'd8,  1'b0};
        vecs[8]  = '{16'hCC04, 16'h0000, 3'b000, 1'b0, 1'b0, 16'h0016, 3'b000, 16'd9,  1'b0};
        vecs[9]  = '{16'h0000, 16'h0000, 3'b101, 1'b0, 1'b0, 16'h0018, 3'b101, 16'd10, 1'b0};
        vecs[10] = '{16'hCC04, 16'h0000, 3'b000, 1'b0, 1'b1, 16'h0022, 3'b101, 16'd11, 1'b0};
        vecs[11] = '{16'h8000, 16'h0000, 3'b010, 1'b0, 1'b0, 16'h0024, 3'b101, 16'd12, 1'b0};
        vecs[12] = '{16'hC60D, 16'h0000, 3'b000, 1'b0, 1'b1, 16'h0040, 3'b101, 16'd13, 1'b0};
        vecs[13] = '{16'hDE00, 16'hBEEF, 3'b000, 1'b0, 1'b1, 16'hBEEF, 3'b101, 16'd14, 1'b0};
        vecs[14] = '{16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 16'hBEF1, 3'b000, 16'd15, 1'b0};
        vecs[15] = '{16'hC400, 16'h0000, 3'b000, 1'b0, 1'b1, 16'hBEF3, 3'b000, 16'd16, 1'b0};
        vecs[16] = '{16'hC200, 16'h0000, 3'b000, 1'b0, 1'b0, 16'hBEF5, 3'b000, 16'd17, 1'b0};
        vecs[17] = '{16'hD000, 16'h0020, 3'b000, 1'b0, 1'b1, 16'h0020, 3'b000, 16'd18, 1'b0};
        vecs[18] = '{16'hCE04, 16'h0000, 3'b111, 1'b1, 1'b1, 16'h0020, 3'b000, 16'd18, 1'b0};
        vecs[19] = '{16'hCE04, 16'h0000, 3'b111, 1'b1, 1'b1, 16'h0020, 3'b000, 16'd18, 1'b0};
        vecs[20] = '{16'hCE04, 16'h0000, 3'b000, 1'b0, 1'b1, 16'h002A, 3'b000, 16'd19, 1'b0};
        vecs[21] = '{16'hDE00, 16'h0020, 3'b000, 1'b0, 1'b1, 16'h0020, 3'b000, 16'd20, 1'b0};
        vecs[22] = '{16'h4000, 16'h0000, 3'b111, 1'b0, 1'b0, 16'h0022, 3'b010, 16'd21, 1'b0};
        vecs[23] = '{16'hDE00, 16'h0020, 3'b000, 1'b0, 1'b1, 16'h0020, 3'b010, 16'd22, 1'b0};
        vecs[24] = '{16'h0000, 16'h0000, 3'b111, 1'b1, 1'b0, 16'h0020, 3'b010, 16'd22, 1'b0};
        vecs[25] = '{16'hF000, 16'h0000, 3'b000, 1'b0, 1'b0, 16'h0020, 3'b010, 16'd23, 1'b1};

        rst = 1'b1;
        instr = 16'h0000;
        rs_data = 16'h0000;
        {alu_n, alu_z, alu_v} = 3'b000;
        stall = 1'b0;
        #1;
        chk("pc_plus2_in_reset", pc_plus2, 16'h0002);
        @(posedge clk);
        #1;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_flags", {13'b0, flags}, 16'h0000);
        chk("rst_count", inst_count, 16'h0000);
        chk("rst_hlt", {15'b0, hlt}, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 26; i++) step(vecs[i]);

        // halted: inputs ignored, taken stays low, nothing moves
        for (int i = 0; i < 10; i++) begin
            instr = (i % 2 == 0) ? 16'hCE04 : 16'($urandom);
            rs_data = 16'($urandom);
            {alu_n, alu_z, alu_v} = 3'($urandom);
            stall = 1'($urandom);
            #4;
            chk("halt_taken", {15'b0, taken}, 16'h0000);
            @(posedge clk);
            #1;
            chk("halt_pc", pc, 16'h0020);
            chk("halt_count", inst_count, 16'd23);
            chk("halt_hlt", {15'b0, hlt}, 16'h0001);
            chk("halt_flags", {13'b0, flags}, 16'h0002);
        end

        // reset wins over stall and HLT
        rst = 1'b1;
        instr = 16'hF000;
        stall = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst2_pc", pc, 16'h0000);
        chk("rst2_hlt", {15'b0, hlt}, 16'h0000);
        chk("rst2_count", inst_count, 16'h0000);
        chk("rst2_flags", {13'b0, flags}, 16'h0000);

        step('{16'hDE00, 16'hFFFE, 3'b000, 1'b0, 1'b1, 16'hFFFE, 3'b000, 16'd1, 1'b0});
        step('{16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 16'h0000, 3'b000, 16'd2, 1'b0});
        step('{16'hCFFE, 16'h0000, 3'b000, 1'b0, 1'b1, 16'hFFFE, 3'b000, 16'd3, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
